// File: rtl/mc8051_int_ctrl.sv
// -----------------------------------------------------------------------------
// mc8051_int_ctrl
//
// Interrupt controller for an 8051-style core. Rising edges on the request
// lines set per-source pending flags. The highest-priority eligible pending
// source is selected and presented to the core with an active-low request.
// The core completes a three-state handshake (IDLE -> REQ -> HOLD) by
// acknowledging. Two in-service bits track which priority levels are
// currently being serviced. Each RETI from the core retires the innermost
// active level.
//
// Ports
//   clk           : single clock, rising edge
//   reset_n       : synchronous active-low reset
//   i_src_req     : per-source request level, a rising edge is an event
//   i_ea          : global interrupt enable
//   i_ie          : per-source enable
//   i_ip          : per-source priority (1 = high, 0 = low)
//   o_int_req_n   : registered interrupt request to the core, active-low
//   o_int_so_num  : registered source index of the current request
//   i_int_ack_n   : core acknowledge, active-low
//   i_int_reti    : one-cycle pulse when the core executes RETI
//   o_pend        : pending flags (SFR readback)
//   o_in_service  : bit1 = high level in service, bit0 = low level in service
// -----------------------------------------------------------------------------
module mc8051_int_ctrl #(
  parameter int N_SRC = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] i_src_req,
  input  logic             i_ea,
  input  logic [N_SRC-1:0] i_ie,
  input  logic [N_SRC-1:0] i_ip,
  output logic             o_int_req_n,
  output logic [7:0]       o_int_so_num,
  input  logic             i_int_ack_n,
  input  logic             i_int_reti,
  output logic [N_SRC-1:0] o_pend,
  output logic [1:0]       o_in_service
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   src_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [1:0]         in_service_q, in_service_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic               sel_lvl_q, sel_lvl_d;
  logic               req_n_q, req_n_d;
  logic [7:0]         so_num_q, so_num_d;

  logic [N_SRC-1:0]   src_rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   eligible_hi;
  logic [N_SRC-1:0]   sel_mask;
  logic               any_eligible;
  logic               any_hi;
  logic [IDX_W-1:0]   win_idx;
  logic               sel_pend;
  logic               sel_ie;
  logic               ack;
  logic               ack_take;
  logic               withdraw;
  logic [1:0]         is_set;
  logic [1:0]         is_clr;

  assign src_rise = i_src_req & ~src_d;
  assign ack      = ~i_int_ack_n;

  // Eligibility and fixed-priority winner: high level first, lowest index
  // within the level. The loop runs from the top down so the last hit is the
  // lowest index.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    eligible    = '0;
    win_idx     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (i_ip[i]) eligible[i] = pend_q[i] & i_ie[i] & i_ea & ~in_service_q[1];
      else         eligible[i] = pend_q[i] & i_ie[i] & i_ea & ~in_service_q[1]
                                 & ~in_service_q[0];
    end
    eligible_hi  = eligible & i_ip;
    any_eligible = |eligible;
    any_hi       = |eligible_hi;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (any_hi ? eligible_hi[i] : eligible[i]) win_idx = IDX_W'(i);
    end
  end

  // One-hot view of the latched selection, used to look up and clear its
  // pend bit and to check its enable without a variable-width index.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sel_mask[i] = (IDX_W'(i) == sel_idx_q);
    end
  end

  assign sel_pend = |(pend_q & sel_mask);
  assign sel_ie   = |(i_ie & sel_mask);
  assign withdraw = ~i_ea | ~sel_ie | ~sel_pend;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    sel_lvl_d = sel_lvl_q;
    so_num_d  = so_num_q;
    req_n_d   = 1'b1;
    ack_take  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An ack seen here is spurious and deliberately ignored.
        if (any_eligible) begin
          state_d   = ST_REQ;
          sel_idx_d = win_idx;
          sel_lvl_d = any_hi;
        end
      end
      ST_REQ: begin
        so_num_d = 8'(sel_idx_q);
        // Ack takes precedence over a simultaneous withdraw condition.
        if (ack) begin
          ack_take = 1'b1;
          state_d  = ST_HOLD;
        end else if (withdraw) begin
          state_d  = ST_IDLE;
        end else begin
          req_n_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pend: a new rising edge beats the ack clear of the same bit.
  assign pend_d = (pend_q & ~(ack_take ? sel_mask : '0)) | src_rise;

  // In-service: RETI retires the innermost registered level. The ack's set is
  // applied last so it survives a coincident RETI on the same bit.
  assign is_clr       = !i_int_reti       ? 2'b00 :
                        in_service_q[1]   ? 2'b10 :
                        in_service_q[0]   ? 2'b01 : 2'b00;
  assign is_set       = !ack_take ? 2'b00 : (sel_lvl_q ? 2'b10 : 2'b01);
  assign in_service_d = (in_service_q & ~is_clr) | is_set;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      src_d        <= '0;
      pend_q       <= '0;
      in_service_q <= 2'b00;
      sel_idx_q    <= '0;
      sel_lvl_q    <= 1'b0;
      req_n_q      <= 1'b1;
      so_num_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      src_d        <= i_src_req;
      pend_q       <= pend_d;
      in_service_q <= in_service_d;
      sel_idx_q    <= sel_idx_d;
      sel_lvl_q    <= sel_lvl_d;
      req_n_q      <= req_n_d;
      so_num_q     <= so_num_d;
    end
  end

  assign o_int_req_n  = req_n_q;
  assign o_int_so_num = so_num_q;
  assign o_pend       = pend_q;
  assign o_in_service = in_service_q;

endmodule

// File: tb/tb_mc8051_int_ctrl.sv
module tb_mc8051_int_ctrl;

  localparam int N_SRC = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N_SRC-1:0] src_req;
  logic             ea;
  logic [N_SRC-1:0] ie;
  logic [N_SRC-1:0] ip;
  logic             int_req_n;
  logic [7:0]       so_num;
  logic             ack_n;
  logic             reti;
  logic [N_SRC-1:0] pend;
  logic [1:0]       in_service;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc8051_int_ctrl #(.N_SRC(N_SRC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_src_req    (src_req),
    .i_ea         (ea),
    .i_ie         (ie),
    .i_ip         (ip),
    .o_int_req_n  (int_req_n),
    .o_int_so_num (so_num),
    .i_int_ack_n  (ack_n),
    .i_int_reti   (reti),
    .o_pend       (pend),
    .o_in_service (in_service)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_src(input logic [N_SRC-1:0] mask);
    src_req = mask;
    tick();
    src_req = '0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  // Ack for one cycle and let HOLD exit; checks the request drops on ack.
  task automatic do_ack(input string name, input logic [1:0] exp_is);
    ack_n = 1'b0;
    tick();
    checks++;
    if (int_req_n !== 1'b1 || in_service !== exp_is) begin
      failures++;
      $display("FAIL %s: req_n=%b in_service=%b, required req_n=1 in_service=%b",
               name, int_req_n, in_service, exp_is);
    end
    ack_n = 1'b1;
    tick();
  endtask

  // Bounded wait for the request, then check the presented source number.
  task automatic wait_req(input string name, input logic [7:0] exp_so);
    int n = 0;
    while (int_req_n !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (int_req_n !== 1'b0) begin
      failures++;
      $display("FAIL %s: request not asserted within 10 cycles, req_n=%b", name, int_req_n);
    end else if (so_num !== exp_so) begin
      failures++;
      $display("FAIL %s: so_num=%h, required %h", name, so_num, exp_so);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; src_req = 5'h01; ea = 1'b1; ie = '0; ip = '0;
    ack_n = 1'b1; reti = 1'b0;
    tick(); tick();
    checks++;
    if (int_req_n !== 1'b1 || so_num !== 8'h00 || pend !== 5'h00 || in_service !== 2'b00) begin
      failures++;
      $display("FAIL reset_values: req_n=%b so=%h pend=%h is=%b, required 1 00 00 00",
               int_req_n, so_num, pend, in_service);
    end
    // Request already high at release counts as a rising edge.
    reset_n = 1'b1;
    tick();
    checks++;
    if (pend !== 5'h01) begin
      failures++;
      $display("FAIL reset_release_edge: pend=%h, required 01", pend);
    end
    reset_n = 1'b0; src_req = '0;
    tick();
    reset_n = 1'b1;
    tick();
    // Spurious ack in IDLE.
    ack_n = 1'b0;
    tick(); tick();
    checks++;
    if (int_req_n !== 1'b1 || in_service !== 2'b00 || pend !== 5'h00) begin
      failures++;
      $display("FAIL spurious_ack: req_n=%b is=%b pend=%h, required 1 00 00",
               int_req_n, in_service, pend);
    end
    ack_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ie = 5'h04; ip = 5'h00;
    pulse_src(5'h04);          // edge n: pend set
    checks++;
    if (pend !== 5'h04 || int_req_n !== 1'b1) begin
      failures++;
      $display("FAIL single_pend: pend=%h req_n=%b, required 04 1", pend, int_req_n);
    end
    tick();                    // edge n+1: enter REQ, request not yet visible
    checks++;
    if (int_req_n !== 1'b1) begin
      failures++;
      $display("FAIL single_latency_early: req_n=%b at n+1, required 1", int_req_n);
    end
    tick();                    // edge n+2
    checks++;
    if (int_req_n !== 1'b0 || so_num !== 8'h02) begin
      failures++;
      $display("FAIL single_req: req_n=%b so=%h at n+2, required 0 02", int_req_n, so_num);
    end
    do_ack("single_ack", 2'b01);
    checks++;
    if (pend !== 5'h00) begin
      failures++;
      $display("FAIL single_pend_clr: pend=%h, required 00", pend);
    end
    pulse_reti();
    checks++;
    if (in_service !== 2'b00) begin
      failures++;
      $display("FAIL single_reti: is=%b, required 00", in_service);
    end
  endtask

  task automatic test_arbitration();
    ie = 5'h19; ip = 5'h18;
    pulse_src(5'h19);
    wait_req("arb_first", 8'h03);
    do_ack("arb_ack3", 2'b10);
    checks++;
    if (pend !== 5'h11) begin
      failures++;
      $display("FAIL arb_pend_after3: pend=%h, required 11", pend);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (int_req_n !== 1'b1) begin
      failures++;
      $display("FAIL arb_blocked: req_n=%b while high in service, required 1", int_req_n);
    end
    pulse_reti();
    wait_req("arb_second", 8'h04);
    do_ack("arb_ack4", 2'b10);
    pulse_reti();
    wait_req("arb_third", 8'h00);
    do_ack("arb_ack0", 2'b01);
    pulse_reti();
    checks++;
    if (pend !== 5'h00 || in_service !== 2'b00) begin
      failures++;
      $display("FAIL arb_done: pend=%h is=%b, required 00 00", pend, in_service);
    end
  endtask

  task automatic test_nesting();
    ie = 5'h03; ip = 5'h01;
    pulse_src(5'h02);
    wait_req("nest_low", 8'h01);
    do_ack("nest_ack_low", 2'b01);
    pulse_src(5'h01);
    wait_req("nest_high", 8'h00);
    do_ack("nest_ack_high", 2'b11);
    pulse_reti();
    checks++;
    if (in_service !== 2'b01) begin
      failures++;
      $display("FAIL nest_reti1: is=%b, required 01", in_service);
    end
    pulse_reti();
    checks++;
    if (in_service !== 2'b00) begin
      failures++;
      $display("FAIL nest_reti2: is=%b, required 00", in_service);
    end
    pulse_reti();
    checks++;
    if (in_service !== 2'b00 || int_req_n !== 1'b1) begin
      failures++;
      $display("FAIL nest_reti_extra: is=%b req_n=%b, required 00 1", in_service, int_req_n);
    end
  endtask

  task automatic test_withdraw();
    ie = 5'h04; ip = 5'h00;
    pulse_src(5'h04);
    wait_req("wd_req", 8'h02);
    ie = 5'h00;
    tick();
    checks++;
    if (int_req_n !== 1'b1 || pend !== 5'h04) begin
      failures++;
      $display("FAIL wd_drop: req_n=%b pend=%h, required 1 04", int_req_n, pend);
    end
    tick(); tick();
    checks++;
    if (int_req_n !== 1'b1) begin
      failures++;
      $display("FAIL wd_stays_off: req_n=%b, required 1", int_req_n);
    end
    ie = 5'h04;
    wait_req("wd_reassert", 8'h02);
    do_ack("wd_ack", 2'b01);
    pulse_reti();
  endtask

  task automatic test_corner();
    ie = 5'h04; ip = 5'h00;
    pulse_src(5'h04);
    wait_req("corner_req", 8'h02);
    // Ack, new edge on the same source and RETI, all in one cycle.
    ack_n = 1'b0; src_req = 5'h04; reti = 1'b1;
    tick();
    checks++;
    if (pend !== 5'h04 || in_service !== 2'b01 || int_req_n !== 1'b1) begin
      failures++;
      $display("FAIL corner_ack_set_wins: pend=%h is=%b req_n=%b, required 04 01 1",
               pend, in_service, int_req_n);
    end
    ack_n = 1'b1; src_req = '0; reti = 1'b0;
    tick();
    pulse_reti();
    wait_req("corner_rereq", 8'h02);
    reset_n = 1'b0;
    tick();
    checks++;
    if (int_req_n !== 1'b1 || so_num !== 8'h00 || pend !== 5'h00 || in_service !== 2'b00) begin
      failures++;
      $display("FAIL corner_reset_in_req: req_n=%b so=%h pend=%h is=%b, required 1 00 00 00",
               int_req_n, so_num, pend, in_service);
    end
    reset_n = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (int_req_n !== 1'b1) begin
      failures++;
      $display("FAIL corner_after_reset: req_n=%b, required 1", int_req_n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_nesting();
    test_withdraw();
    test_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc8051_int_ctrl.md
MC8051_INT_CTRL -- requirements
Module: mc8051_int_ctrl

Interface
REQ-001 Parameter: N_SRC, default 5, number of interrupt sources (1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 i_src_req  input  N_SRC  per-source request level; a rising edge is an event.
REQ-005 i_ea  input  1  global interrupt enable.
REQ-006 i_ie  input  N_SRC  per-source enable.
REQ-007 i_ip  input  N_SRC  per-source priority: 1 = high, 0 = low.
REQ-008 o_int_req_n  output  1  interrupt request to core, active-low.
REQ-009 o_int_so_num  output  8  source index of the current request, zero-extended.
REQ-010 i_int_ack_n  input  1  core acknowledge, active-low, at least one cycle.
REQ-011 i_int_reti  input  1  one-cycle pulse when the core executes RETI.
REQ-012 o_pend  output  N_SRC  pending flags, for SFR readback.
REQ-013 o_in_service  output  2  bit1 = high level in service, bit0 = low level in service.

Function
REQ-014 Edge detect: each cycle, register i_src_req into src_d; src_rise = i_src_req & ~src_d.
REQ-015 A source's pend bit sets on src_rise.
REQ-016 A source's pend bit clears on ack of that source.
REQ-017 When set and clear hit the same bit in the same cycle, set wins.
REQ-018 Eligible(i) = pend[i] & i_ie[i] & i_ea & level gate.
REQ-019 Level gate for high (i_ip[i]=1): ~in_service[1].
REQ-020 Level gate for low (i_ip[i]=0): ~in_service[1] & ~in_service[0].
REQ-021 Winner selection: highest eligible priority level first, then lowest source index; purely combinational, evaluated in IDLE only.
REQ-022 States: IDLE, REQ, HOLD; encoding is free.
REQ-023 IDLE -> REQ when any source is eligible.
REQ-024 On that transition, latch winner index and level into sel_idx / sel_lvl.
REQ-025 From the next cycle: o_int_req_n = 0, o_int_so_num = sel_idx.
REQ-026 REQ: o_int_req_n low and o_int_so_num stable until exit; no re-arbitration, so a later higher-priority event waits.
REQ-027 REQ -> HOLD when i_int_ack_n is sampled 0.
REQ-028 Ack effects, same edge: clear pend[sel_idx]; set in_service[sel_lvl]; o_int_req_n = 1.
REQ-029 REQ -> IDLE (withdraw) when i_ea = 0, i_ie[sel_idx] = 0, or pend[sel_idx] = 0, with i_int_ack_n = 1. o_int_req_n returns to 1 on the next edge; pend is unchanged.
REQ-030 If ack and a withdraw condition coincide, ack wins.
REQ-031 HOLD: o_int_req_n = 1; stay while i_int_ack_n = 0.
REQ-032 HOLD -> IDLE when i_int_ack_n = 1. This guarantees at least one deasserted cycle between requests.
REQ-033 i_int_reti clears in_service[1] if set, else in_service[0] if set; with neither set it is ignored, no error.
REQ-034 reti is evaluated on registered in_service. If reti and an ack setting the same bit occur in one cycle, the bit ends set; the ack's set wins.
REQ-035 Nesting: high may preempt low (both bits set); the next reti returns to the low level; low never preempts anything.
REQ-036 i_int_ack_n low in IDLE (spurious): ignored, no state change.
REQ-037 o_pend and o_in_service are direct register outputs; o_int_req_n and o_int_so_num are registered, with no combinational path from inputs.
REQ-038 Latency: edge on i_src_req at clock edge n sets pend at n; req is asserted at n+2, provided the controller is in IDLE and the source is eligible.

Reset
REQ-039 While reset_n = 0 at a clock edge: state = IDLE, o_int_req_n = 1, o_int_so_num = 0, o_pend = 0, o_in_service = 0, src_d = 0, sel_idx = 0, sel_lvl = 0.
REQ-040 Reset asserted mid-REQ or mid-HOLD aborts the handshake. Pending events are lost.
REQ-041 If i_src_req is high when reset releases, src_d starts at 0, so this is a rising edge on the first post-reset cycle.

Verification
REQ-042 Single source: i_ea = 1, i_ie = 5'h04, i_ip = 0; pulse i_src_req[2] -> o_int_req_n = 0 two edges later with o_int_so_num = 8'h02. Ack -> o_pend[2] = 0, o_in_service = 2'b01, req = 1.
REQ-043 Arbitration: rising edges on src 0, 3, 4 in the same cycle with i_ip = 5'h18 -> first request so_num = 3. After ack and HOLD exit, src 4 is high priority but blocked by in_service[1] until reti. After reti, so_num = 4 is requested; after its ack and a second reti, so_num = 0 is requested.
REQ-044 Nesting: src 1 low, acked (in_service = 01); then a src 0 high edge -> req with so_num = 0, ack -> in_service = 11. reti -> 01; reti -> 00; extra reti -> 00, no effect.
REQ-045 Withdraw: in REQ for src 2, drop i_ie[2] with ack high -> o_int_req_n = 1 next edge, o_pend[2] stays 1. Re-enable -> request reasserts with so_num = 2.
REQ-046 Corner cases: a new src_rise on sel_idx in the ack cycle -> pend stays 1. reti and ack of the same level in one cycle -> in_service bit stays 1. reset_n = 0 during REQ -> all outputs at reset values next edge.
